// File: rtl/game_pkg.sv
// Shared types and defaults for the game sequencer slice.
package game_pkg;

    localparam int Y_W         = 26;
    localparam int DEF_SCORE_W = 16;
    localparam int DEF_ROW_H   = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_DYING     = 3'd4,
        ST_OVER      = 3'd5
    } game_state_e;

endpackage

// File: rtl/game_seq_ctrl_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, in every game state.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/game_seq_ctrl.sv
// Game sequencer: countdown, play, pause, death and game-over around the ball datapath.
// Lives and score are tracked here; every output is a flop.
module game_seq_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 1_000_000,
    parameter int CD_TICKS     = 50,
    parameter int FAIL_CONFIRM = 4,
    parameter int DEATH_TICKS  = 100,
    parameter int LIVES        = 3,
    parameter int ROW_H        = DEF_ROW_H,
    parameter int SCORE_W      = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               fail,
    input  logic [Y_W-1:0]     y_ball,
    output logic               ball_en,
    output logic               ball_rst,
    output logic [2:0]         game_state,
    output logic [1:0]         countdown,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int PH_MAX = (CD_TICKS > DEATH_TICKS) ? CD_TICKS : DEATH_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int FC_W   = $clog2(FAIL_CONFIRM + 1);

    localparam logic [PH_W-1:0] CD_LAST    = PH_W'(CD_TICKS - 1);
    localparam logic [PH_W-1:0] DEATH_LAST = PH_W'(DEATH_TICKS - 1);
    localparam logic [FC_W-1:0] FC_LIMIT   = FC_W'(FAIL_CONFIRM);

    game_state_e     state;
    logic            tick;
    logic [PH_W-1:0] phase;
    logic [FC_W-1:0] fail_cnt;
    logic [Y_W-1:0]  best_y;

    logic [Y_W:0]    row_next;
    logic            score_hit;
    logic [FC_W-1:0] fail_nxt;
    logic            death_hit;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // One extra bit so best_y + ROW_H near the top of the y range cannot wrap.
    assign row_next  = {1'b0, best_y} + (Y_W + 1)'(ROW_H);
    assign score_hit = ({1'b0, y_ball} >= row_next);
    assign fail_nxt  = fail ? (fail_cnt + FC_W'(1)) : '0;
    assign death_hit = (fail_nxt == FC_LIMIT);

    assign game_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ball_en   <= 1'b0;
            ball_rst  <= 1'b1;
            countdown <= 2'd0;
            lives     <= 2'(LIVES);
            score     <= '0;
            game_over <= 1'b0;
            fail_cnt  <= '0;
            phase     <= '0;
            best_y    <= '0;
        end else begin
            ball_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ball_rst  <= 1'b1;
                    game_over <= 1'b0;
                    if (btn_start) begin
                        state     <= ST_COUNTDOWN;
                        lives     <= 2'(LIVES);
                        score     <= '0;
                        best_y    <= '0;
                        countdown <= 2'd3;
                        phase     <= '0;
                        fail_cnt  <= '0;
                        ball_rst  <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    ball_rst <= 1'b0;
                    if (tick) begin
                        if (phase == CD_LAST) begin
                            phase <= '0;
                            if (countdown == 2'd1) begin
                                state     <= ST_PLAY;
                                countdown <= 2'd0;
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // Pause wins outright; the tick's fail/score work is skipped, so fail_cnt survives.
                    if (btn_pause) begin
                        state <= ST_PAUSE;
                    end else if (tick) begin
                        ball_en <= 1'b1;
                        if (score_hit) begin
                            best_y <= row_next[Y_W-1:0];
                            if (score != '1)
                                score <= score + SCORE_W'(1);
                        end
                        if (death_hit) begin
                            state    <= ST_DYING;
                            lives    <= lives - 2'd1;
                            fail_cnt <= '0;
                            phase    <= '0;
                        end else begin
                            fail_cnt <= fail_nxt;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_pause)
                        state <= ST_PLAY;
                end
                ST_DYING: begin
                    if (tick) begin
                        if (phase == DEATH_LAST) begin
                            phase <= '0;
                            if (lives == 2'd0) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                                ball_rst  <= 1'b1;
                            end else begin
                                // Respawn: ball_rst is high only for the first COUNTDOWN cycle.
                                state     <= ST_COUNTDOWN;
                                ball_rst  <= 1'b1;
                                best_y    <= '0;
                                countdown <= 2'd3;
                                fail_cnt  <= '0;
                            end
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                    ball_rst  <= 1'b1;
                    if (btn_start) begin
                        state     <= ST_IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
